// File: rtl/minterm_fn_engine_pkg.sv
// Shared types and constants for the programmable sum-of-minterms engine.
package minterm_fn_engine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  // Standard 3-input functions, bit i = value of minterm i
  localparam logic [7:0] SOP_02467 = 8'hD5;
  localparam logic [7:0] FN_A3     = 8'hF0;
  localparam logic [7:0] FN_XOR3   = 8'h96;

  function automatic int calc_mw(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int calc_ch_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/minterm_fn_engine_if.sv
// Evaluation, configuration and counter signals of the minterm engine.
interface minterm_fn_engine_if
  import minterm_fn_engine_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_CH  = 2,
  parameter int CNT_W = 8
) ();
  localparam int CH_W = calc_ch_w(N_CH);

  logic                    in_valid;
  logic [N_IN-1:0]         in_vars;
  logic                    out_valid;
  logic [N_CH-1:0]         out_f;
  logic                    cfg_start;
  logic [CH_W-1:0]         cfg_ch;
  logic                    cfg_bit;
  logic                    cfg_ready;
  logic                    cfg_done;
  logic                    cfg_err;
  logic                    cnt_clr;
  logic [N_CH*CNT_W-1:0]   hit_cnt;

  modport slave (
    input  in_valid, in_vars, cfg_start, cfg_ch, cfg_bit, cnt_clr,
    output out_valid, out_f, cfg_ready, cfg_done, cfg_err, hit_cnt
  );

  modport master (
    output in_valid, in_vars, cfg_start, cfg_ch, cfg_bit, cnt_clr,
    input  out_valid, out_f, cfg_ready, cfg_done, cfg_err, hit_cnt
  );
endinterface

// File: rtl/minterm_fn_engine_channel.sv
// One function channel: minterm mask, registered lookup and saturating hit counter.
module minterm_fn_channel
  import minterm_fn_engine_pkg::*;
#(
  parameter int                        N_IN     = 3,
  parameter int                        CNT_W    = 8,
  parameter logic [calc_mw(N_IN)-1:0]  MASK_RST = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  input  logic [N_IN-1:0]           in_vars_i,
  input  logic                      mask_we_i,
  input  logic [calc_mw(N_IN)-1:0]  mask_i,
  input  logic                      cnt_clr_i,
  output logic                      f_o,
  output logic [CNT_W-1:0]          cnt_o
);
  localparam int MW = calc_mw(N_IN);

  logic [MW-1:0]    mask_q;
  logic             f_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  assign hit = in_valid_i & mask_q[in_vars_i];

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                 cnt_d = '0;
    else if (hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Lookup reads mask_q before a same-edge write lands, so the switch is atomic
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= MASK_RST;
      f_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (mask_we_i)  mask_q <= mask_i;
      if (in_valid_i) f_q    <= mask_q[in_vars_i];
      cnt_q <= cnt_d;
    end
  end

  assign f_o   = f_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/minterm_fn_engine.sv
// N_CH programmable minterm channels sharing one input vector, plus the serial mask loader.
module minterm_fn_engine
  import minterm_fn_engine_pkg::*;
#(
  parameter int                             N_IN          = 3,
  parameter int                             N_CH          = 2,
  parameter int                             CNT_W         = 8,
  parameter logic [N_CH*calc_mw(N_IN)-1:0]  DEFAULT_MASKS = {FN_A3, SOP_02467}
) (
  input  logic                 clk,
  input  logic                 rst,
  minterm_fn_engine_if.slave   bus
);
  localparam int               MW     = calc_mw(N_IN);
  localparam int               CH_W   = calc_ch_w(N_CH);
  localparam logic [N_IN:0]    MW_CNT = (N_IN+1)'(MW);
  localparam logic [CH_W:0]    N_CH_C = (CH_W+1)'(N_CH);

  cfg_state_e              state_q, state_d;
  logic [CH_W-1:0]         ch_q;
  logic [N_IN:0]           bit_cnt_q;
  logic [MW-1:0]           shift_q;
  logic                    out_valid_q;
  logic                    ch_ok, commit_ok;
  logic [N_CH-1:0]         f;
  logic [N_CH-1:0][CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Counter reaching MW is seen for one cycle in SHIFT before moving to COMMIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cfg_start) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == MW_CNT) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_ok         = ({1'b0, ch_q} < N_CH_C);
    commit_ok     = (state_q == COMMIT) && ch_ok;
    bus.cfg_ready = (state_q == IDLE);
    bus.cfg_done  = commit_ok;
    bus.cfg_err   = (state_q == COMMIT) && !ch_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q        <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (state_q == IDLE && bus.cfg_start) begin
        ch_q      <= bus.cfg_ch;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT && bit_cnt_q != MW_CNT) begin
        shift_q   <= {shift_q[MW-2:0], bus.cfg_bit};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    minterm_fn_channel #(
      .N_IN     (N_IN),
      .CNT_W    (CNT_W),
      .MASK_RST (DEFAULT_MASKS[k*MW +: MW])
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (bus.in_valid),
      .in_vars_i  (bus.in_vars),
      .mask_we_i  (commit_ok && (ch_q == CH_W'(k))),
      .mask_i     (shift_q),
      .cnt_clr_i  (bus.cnt_clr),
      .f_o        (f[k]),
      .cnt_o      (cnt[k])
    );
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = f;
  assign bus.hit_cnt   = cnt;
endmodule

// File: tb/tb_minterm_fn_engine.sv
// Directed checks of evaluation, serial mask load, counters and reset for minterm_fn_engine.
module tb_minterm_fn_engine;
  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  minterm_fn_engine_if #(.N_IN(3), .N_CH(2), .CNT_W(8)) bus1 ();
  minterm_fn_engine_if #(.N_IN(3), .N_CH(3), .CNT_W(3)) bus2 ();

  minterm_fn_engine #(.N_IN(3), .N_CH(2), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );

  // ch0 = all-ones, ch1 = A, ch2 = sum(2,3,4,5); a 3-channel instance has an illegal cfg_ch (3)
  minterm_fn_engine #(.N_IN(3), .N_CH(3), .CNT_W(3), .DEFAULT_MASKS(24'h3CF0FF)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  typedef struct {
    logic [2:0] vars;
    logic [1:0] f;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string nm, input vec_t tbl[8]);
    for (int i = 0; i < 8; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_vars  = tbl[i].vars;
      step();
      chk({nm, "_valid"}, bus1.out_valid, 1);
      chk({nm, "_f"}, bus1.out_f, tbl[i].f);
    end
    bus1.in_valid = 1'b0;
  endtask

  task automatic load1(input logic ch, input logic [7:0] m,
                       output int low, output int dn, output int er);
    bus1.cfg_start = 1'b1;
    bus1.cfg_ch    = ch;
    step();
    bus1.cfg_start = 1'b0;
    low = 0; dn = 0; er = 0;
    for (int j = 0; j < 20 && !bus1.cfg_ready; j++) begin
      low++;
      if (bus1.cfg_done) dn++;
      if (bus1.cfg_err)  er++;
      bus1.cfg_bit = (j < 8) ? m[7-j] : 1'b0;
      step();
    end
    chk("load_ready_return", bus1.cfg_ready, 1);
  endtask

  vec_t sw_def[8], sw_xor[8];
  int low, dn, er;

  initial begin
    sw_def = '{'{3'd0, 2'b01}, '{3'd1, 2'b00}, '{3'd2, 2'b01}, '{3'd3, 2'b00},
               '{3'd4, 2'b11}, '{3'd5, 2'b10}, '{3'd6, 2'b11}, '{3'd7, 2'b11}};
    sw_xor = '{'{3'd0, 2'b01}, '{3'd1, 2'b10}, '{3'd2, 2'b11}, '{3'd3, 2'b00},
               '{3'd4, 2'b11}, '{3'd5, 2'b00}, '{3'd6, 2'b01}, '{3'd7, 2'b11}};

    rst1 = 1'b1; rst2 = 1'b1;
    bus1.in_valid = 0; bus1.in_vars = 0; bus1.cfg_start = 0; bus1.cfg_ch = 0;
    bus1.cfg_bit = 0; bus1.cnt_clr = 0;
    bus2.in_valid = 0; bus2.in_vars = 0; bus2.cfg_start = 0; bus2.cfg_ch = 0;
    bus2.cfg_bit = 0; bus2.cnt_clr = 0;
    repeat (2) step();

    chk("rst_out_valid", bus1.out_valid, 0);
    chk("rst_out_f",     bus1.out_f, 0);
    chk("rst_hit_cnt",   bus1.hit_cnt, 0);
    chk("rst_cfg_ready", bus1.cfg_ready, 1);
    chk("rst_cfg_done",  bus1.cfg_done, 0);
    chk("rst_cfg_err",   bus1.cfg_err, 0);
    rst1 = 1'b0; rst2 = 1'b0;

    // Default masks: ch0 = sum(0,2,4,6,7), ch1 = A
    sweep("sweep_def", sw_def);
    chk("hit_ch0", bus1.hit_cnt[7:0], 5);
    chk("hit_ch1", bus1.hit_cnt[15:8], 4);
    step();
    chk("idle_valid", bus1.out_valid, 0);
    chk("idle_hold_f", bus1.out_f, 2'b11);

    // Serial load of XOR3 into ch1, MSB first
    load1(1'b1, 8'h96, low, dn, er);
    chk("xor_low_cycles", low, 10);
    chk("xor_done_pulses", dn, 1);
    chk("xor_err_pulses", er, 0);
    sweep("sweep_xor", sw_xor);

    // Atomic switch: results through the COMMIT edge use the old ch0 mask
    bus1.in_valid  = 1'b1;
    bus1.in_vars   = 3'b111;
    bus1.cfg_start = 1'b1;
    bus1.cfg_ch    = 1'b0;
    bus1.cfg_bit   = 1'b0;
    step();
    bus1.cfg_start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      chk($sformatf("hold_f0_k%0d", k), bus1.out_f[0], (k <= 10) ? 1 : 0);
      chk($sformatf("hold_f1_k%0d", k), bus1.out_f[1], 1);
      chk($sformatf("hold_done_k%0d", k), bus1.cfg_done, (k == 9) ? 1 : 0);
      step();
    end
    bus1.in_valid = 1'b0;

    // Saturating counter on the CNT_W=3 instance, ch0 mask all-ones
    bus2.in_vars = 3'd0;
    bus2.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("sat_cnt_k%0d", k), bus2.hit_cnt[2:0], (k + 1 > 7) ? 7 : k + 1);
    end
    chk("sat_ch1", bus2.hit_cnt[5:3], 0);
    bus2.cnt_clr = 1'b1;
    step();
    chk("clr_wins", bus2.hit_cnt[2:0], 0);
    bus2.cnt_clr = 1'b0;
    step();
    chk("cnt_after_clr", bus2.hit_cnt[2:0], 1);
    bus2.in_valid = 1'b0;

    // Illegal channel: zeros shifted, cfg_err only, stray cfg_start ignored
    bus2.cfg_start = 1'b1;
    bus2.cfg_ch    = 2'd3;
    bus2.cfg_bit   = 1'b0;
    step();
    bus2.cfg_start = 1'b0;
    dn = 0; er = 0;
    for (int k = 0; k < 13; k++) begin
      if (k == 2) begin bus2.cfg_start = 1'b1; bus2.cfg_ch = 2'd0; end
      else bus2.cfg_start = 1'b0;
      if (bus2.cfg_done) dn++;
      chk($sformatf("err_pulse_k%0d", k), bus2.cfg_err, (k == 9) ? 1 : 0);
      step();
    end
    chk("err_no_done", dn, 0);
    chk("err_ready", bus2.cfg_ready, 1);
    bus2.cfg_start = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.in_vars  = 3'd1;
    step();
    chk("err_masks_v1", bus2.out_f, 3'b001);
    bus2.in_vars  = 3'd5;
    step();
    chk("err_masks_v5", bus2.out_f, 3'b111);
    bus2.in_valid = 1'b0;

    // Reset in the 4th SHIFT cycle abandons the load and restores defaults
    bus1.cfg_start = 1'b1;
    bus1.cfg_ch    = 1'b1;
    bus1.cfg_bit   = 1'b0;
    step();
    bus1.cfg_start = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_vars   = 3'd7;
    repeat (3) step();
    chk("pre_rst_ready", bus1.cfg_ready, 0);
    rst1 = 1'b1;
    step();
    chk("midrst_ready", bus1.cfg_ready, 1);
    chk("midrst_valid", bus1.out_valid, 0);
    chk("midrst_f", bus1.out_f, 0);
    chk("midrst_cnt", bus1.hit_cnt, 0);
    rst1 = 1'b0;
    bus1.in_valid = 1'b0;
    sweep("sweep_after_rst", sw_def);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
